aes_mmio_bridge: RTL

Memory-mapped front end that lets the core's load/store port drive the AES accelerator (`aes_top_level`). It sits directly upstream of the accelerator: CPU word writes fill the accelerator's 1024-word buffer, a control register write launches an operation, and CPU reads return buffer contents or status. It also sequences the accelerator control code, latches completion, and counts busy cycles.

---
 rtl/aes_mmio_bridge.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/aes_mmio_bridge.sv
`timescale 1ns/1ps
// MMIO front end for aes_top_level: buffer window, CTRL/STATUS/CYCLES registers,
// accelerator opcode sequencing and fixed-latency buffer reads.
//
// state   | meaning
// IDLE    | accelerator idle, buffer writes forwarded, new op may start
// RUN     | opcode driven, waiting for aes_complete_in, buffer writes rejected
module aes_mmio_bridge #(
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [12:0] bus_addr_in,
   input  logic [31:0] bus_wdata_in,
   input  logic [3:0]  bus_we_in,
   input  logic        bus_re_in,
   output logic [31:0] bus_rdata_out,
   output logic        bus_rvalid_out,
   output logic        bus_stall_out,
   output logic        irq_out,
   output logic [2:0]  aes_ctrl_out,
   output logic [3:0]  aes_mem_we_out,
   output logic [9:0]  aes_mem_wr_addr_out,
   output logic [9:0]  aes_mem_rd_addr_out,
   output logic [31:0] aes_data_out,
   input  logic [31:0] aes_data_in,
   input  logic        aes_complete_in
);

   localparam logic [12:0] ADDR_CTRL   = 13'h1000;
   localparam logic [12:0] ADDR_STATUS = 13'h1004;
   localparam logic [12:0] ADDR_CYCLES = 13'h1008;
   localparam int          CNT_W       = $clog2(RD_LATENCY + 2);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic              ie_q, ie_d, done_q, done_d, err_q, err_d;
   logic [31:0]       cycles_q, cycles_d;
   logic [3:0]        mem_we_q, mem_we_d;
   logic [9:0]        wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d, stall_q, stall_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              busy, in_win, wr_req, rd_req;
   logic [31:0]       reg_rdata;

   assign busy   = (state_q == ST_RUN);
   assign in_win = ~bus_addr_in[12];
   assign wr_req = ~stall_q && (bus_we_in != 4'd0);
   assign rd_req = ~stall_q && bus_re_in && (bus_we_in == 4'd0);

   always_comb begin
      case (bus_addr_in)
         ADDR_CTRL:   reg_rdata = {27'd0, 1'b0, ie_q, ctrl_q};
         ADDR_STATUS: reg_rdata = {29'd0, err_q, done_q, busy};
         ADDR_CYCLES: reg_rdata = cycles_q;
         default:     reg_rdata = 32'd0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      ie_d      = ie_q;
      done_d    = done_q;
      err_d     = err_q;
      cycles_d  = cycles_q;
      mem_we_d  = 4'd0;
      wr_addr_d = wr_addr_q;
      wdata_d   = wdata_q;
      rd_addr_d = rd_addr_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      stall_d   = stall_q;
      cnt_d     = cnt_q;

      if (busy && cycles_q != 32'hFFFF_FFFF)
         cycles_d = cycles_q + 32'd1;

      if (wr_req && bus_addr_in == ADDR_CTRL) begin
         ie_d = bus_wdata_in[3];
         if (bus_wdata_in[4])
            done_d = 1'b0;
         // start overrides everything else written in the same cycle
         if (!busy && bus_wdata_in[2:0] != 3'd0) begin
            state_d  = ST_RUN;
            ctrl_d   = bus_wdata_in[2:0];
            done_d   = 1'b0;
            err_d    = 1'b0;
            cycles_d = 32'd0;
         end
      end

      if (wr_req && in_win) begin
         if (busy) begin
            err_d = 1'b1;
         end else begin
            mem_we_d  = bus_we_in;
            wr_addr_d = bus_addr_in[11:2];
            wdata_d   = bus_wdata_in;
         end
      end

      if (busy && aes_complete_in) begin
         state_d = ST_IDLE;
         ctrl_d  = 3'd0;
         done_d  = 1'b1;
      end

      if (rd_req) begin
         if (in_win) begin
            rd_addr_d = bus_addr_in[11:2];
            stall_d   = 1'b1;
            cnt_d     = CNT_W'(RD_LATENCY);
         end else begin
            rvalid_d = 1'b1;
            rdata_d  = reg_rdata;
         end
      end

      // capture on the RD_LATENCY-th edge after the read address was driven
      if (stall_q) begin
         if (cnt_q <= CNT_W'(1)) begin
            stall_d  = 1'b0;
            rvalid_d = 1'b1;
            rdata_d  = aes_data_in;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= ST_IDLE;
         ctrl_q    <= 3'd0;
         ie_q      <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cycles_q  <= 32'd0;
         mem_we_q  <= 4'd0;
         wr_addr_q <= 10'd0;
         wdata_q   <= 32'd0;
         rd_addr_q <= 10'd0;
         rdata_q   <= 32'd0;
         rvalid_q  <= 1'b0;
         stall_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         ie_q      <= ie_d;
         done_q    <= done_d;
         err_q     <= err_d;
         cycles_q  <= cycles_d;
         mem_we_q  <= mem_we_d;
         wr_addr_q <= wr_addr_d;
         wdata_q   <= wdata_d;
         rd_addr_q <= rd_addr_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         stall_q   <= stall_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus_rdata_out       = rdata_q;
   assign bus_rvalid_out      = rvalid_q;
   assign bus_stall_out       = stall_q;
   assign irq_out             = done_q & ie_q;
   assign aes_ctrl_out        = ctrl_q;
   assign aes_mem_we_out      = mem_we_q;
   assign aes_mem_wr_addr_out = wr_addr_q;
   assign aes_mem_rd_addr_out = rd_addr_q;
   assign aes_data_out        = wdata_q;

endmodule
